// File: rtl/muldiv_seq.sv
// Iterative signed/unsigned multiply and restoring divide for the HI/LO unit.
// One shared add/sub path is reused for every iteration; sign fix-up happens in a final cycle.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 is_div_reg;
    logic                 psign_reg;
    logic                 rsign_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 dbz_reg;
    logic                 ovf_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;

    logic                 accept;
    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 in_dbz;
    logic                 in_ovf;

    logic                 c0;
    logic [WIDTH+1:0]     add_x;
    logic [WIDTH+1:0]     add_y;
    logic [WIDTH+1:0]     add_sum;
    logic [2*WIDTH-1:0]   acc_next;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    always_comb begin
        accept    = start && (state_reg == IDLE || state_reg == DONE);
        signed_op = ~op[0];
        a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
        in_dbz    = op[1] && (b == '0);
        in_ovf    = (op == 2'b10) && (a == MIN_NEG) && (b == '1);
    end

    // Two guard bits: divide needs the shifted-in remainder bit plus a borrow bit,
    // multiply needs the carry out of the upper half.
    always_comb begin
        c0      = is_div_reg;
        add_x   = is_div_reg ? {1'b0, acc_reg[2*WIDTH-1:WIDTH-1]}
                             : {2'b00, acc_reg[2*WIDTH-1:WIDTH]};
        add_y   = {2'b00, mcand_reg};
        add_sum = add_x + (add_y ^ {(WIDTH+2){c0}}) + {{(WIDTH+1){1'b0}}, c0};
        if (is_div_reg) begin
            if (!add_sum[WIDTH+1])
                acc_next = {add_sum[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
            else
                acc_next = {acc_reg[2*WIDTH-2:WIDTH-1], acc_reg[WIDTH-2:0], 1'b0};
        end else if (acc_reg[0]) begin
            acc_next = {add_sum[WIDTH:0], acc_reg[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc_reg[2*WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = psign_reg ? -acc_reg : acc_reg;
        quo_fix  = psign_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fix  = rsign_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
        fix_hi   = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            psign_reg  <= 1'b0;
            rsign_reg  <= 1'b0;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        is_div_reg <= op[1];
                        psign_reg  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rsign_reg  <= signed_op & a[WIDTH-1];
                        dbz_reg    <= in_dbz;
                        ovf_reg    <= in_ovf;
                        cnt_reg    <= '0;
                        mcand_reg  <= op[1] ? b_mag : a_mag;
                        acc_reg    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        if (in_dbz) begin
                            hi_reg    <= a;
                            lo_reg    <= '1;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            busy_reg  <= 1'b1;
                            state_reg <= CALC;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH-1))
                        state_reg <= FIX;
                end
                FIX: begin
                    hi_reg    <= fix_hi;
                    lo_reg    <= fix_lo;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign div_by_zero = dbz_reg;
    assign ovf         = ovf_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: vector table, randomised model vectors, and hand-written
// sequences for back-to-back accept, ignored start, divide-by-zero and mid-op reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    logic        ovf;

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l,
                                input logic z, input logic v);
        exp_t e;
        e.hi = h; e.lo = l; e.dbz = z; e.ovf = v;
        e.lat = z ? 1 : 34;
        return e;
    endfunction

    // Behavioural reference using native 64-bit and int arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int          sx;
        int          sy;
        longint      sp;
        logic [63:0] p;
        int          q;
        int          r;
        sx = x;
        sy = y;
        case (o)
            2'b00: begin
                sp = longint'(sx) * longint'(sy);
                p  = sp;
                return mk(p[63:32], p[31:0], 1'b0, 1'b0);
            end
            2'b01: begin
                p = {32'b0, x} * {32'b0, y};
                return mk(p[63:32], p[31:0], 1'b0, 1'b0);
            end
            2'b10: begin
                if (y == 0) return mk(x, 32'hFFFF_FFFF, 1'b1, 1'b0);
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return mk(32'h0, 32'h8000_0000, 1'b0, 1'b1);
                q = sx / sy;
                r = sx % sy;
                return mk(r, q, 1'b0, 1'b0);
            end
            default: begin
                if (y == 0) return mk(x, 32'hFFFF_FFFF, 1'b1, 1'b0);
                return mk(x % y, x / y, 1'b0, 1'b0);
            end
        endcase
    endfunction

    // Drives start for one edge; returns 1 time unit after the accepting edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lat0);
        int   lat;
        logic busy_bad;
        exp_t e;
        lat      = lat0;
        busy_bad = 1'b0;
        while (!done && lat < 100) begin
            if (!busy) busy_bad = 1'b1;
            tick;
            lat++;
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty at done", name);
            return;
        end
        e = sb.pop_front();
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done, expected done within 100 edges", name);
            return;
        end
        chk({name, "_hi"},   64'(hi), 64'(e.hi));
        chk({name, "_lo"},   64'(lo), 64'(e.lo));
        chk({name, "_dbz"},  64'(div_by_zero), 64'(e.dbz));
        chk({name, "_ovf"},  64'(ovf), 64'(e.ovf));
        chk({name, "_lat"},  64'(lat), 64'(e.lat));
        chk({name, "_busyrun"}, 64'(busy_bad), 64'(0));
        chk({name, "_busydone"}, 64'(busy), 64'(0));
        $display("txn %s op=%0d a=%h b=%h hi=%h lo=%h dbz=%0d ovf=%0d lat=%0d",
                 name, op, a, b, hi, lo, div_by_zero, ovf, lat);
    endtask

    vec_t vecs[12];

    initial begin
        int   n;
        int   ones;
        exp_t e;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0};
        vecs[4]  = '{2'b11, 32'h0000_0064, 32'h0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 1'b1};
        vecs[6]  = '{2'b00, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0, 1'b0};
        vecs[9]  = '{2'b10, 32'h0,         32'd5,         32'h0,         32'h0,         1'b0, 1'b0};
        vecs[10] = '{2'b10, 32'hFFFF_FFF8, 32'h0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[11] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0,         1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        tick; tick;
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi",   64'(hi),   64'(0));
        chk("rst_lo",   64'(lo),   64'(0));
        chk("rst_dbz",  64'(div_by_zero), 64'(0));
        chk("rst_ovf",  64'(ovf),  64'(0));
        tick;

        for (int i = 0; i < 12; i++) begin
            sb.push_back(mk(vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].ovf));
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), 1);
            tick;
        end

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'h0 : $urandom >> $urandom_range(0, 28);
            sb.push_back(model(ro, ra, rb));
            launch(ro, ra, rb);
            wait_done($sformatf("rnd%0d", i), 1);
            tick;
        end

        // Divide by zero followed by an accept that must clear the flag.
        sb.push_back(mk(32'h64, 32'hFFFF_FFFF, 1'b1, 1'b0));
        launch(2'b11, 32'h64, 32'h0);
        wait_done("dbz", 1);
        tick;
        sb.push_back(mk(32'd2, 32'd14, 1'b0, 1'b0));
        launch(2'b11, 32'd100, 32'd7);
        chk("dbz_cleared", 64'(div_by_zero), 64'(0));
        chk("busy_after_e1", 64'(busy), 64'(1));
        wait_done("dbz_next", 1);
        tick;

        // Overflow divide, then back-to-back MULTU accepted in its done cycle.
        sb.push_back(mk(32'h0, 32'h8000_0000, 1'b0, 1'b1));
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("ovf", 1);
        sb.push_back(mk(32'h0, 32'd12, 1'b0, 1'b0));
        launch(2'b01, 32'd3, 32'd4);
        chk("b2b_ovf_cleared", 64'(ovf), 64'(0));
        wait_done("b2b", 1);
        tick;

        // start while busy is ignored.
        sb.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 1'b0));
        launch(2'b00, 32'd7, 32'hFFFF_FFFA);
        tick; tick; tick;
        op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done("ignore", 5);
        tick;

        // Reset at E10 of a multiply discards it.
        launch(2'b00, 32'd123, 32'd456);
        for (int i = 0; i < 8; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_hi",   64'(hi),   64'(0));
        chk("midrst_lo",   64'(lo),   64'(0));
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) ones++;
            tick;
        end
        chk("midrst_idle", 64'(ones), 64'(0));
        n = 0;
        sb.push_back(model(2'b00, 32'd123, 32'd456));
        launch(2'b00, 32'd123, 32'd456);
        wait_done("after_rst", 1);
        tick;

        chk("sb_empty", 64'(sb.size()), 64'(n));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
